mdr_operand_loader: RTL
=======================

// Module: mdr_operand_loader
// PURPOSE
// Front-end stage of the multiply/divide/root (MDR) system, directly upstream of the calculation core.
// Captures operation code, operand X and (for MULT/DIV) operand Y from a shared DW-bit bus via load strobes.
// Checks the operands and hands magnitudes plus a result-sign flag to the core with a valid/accept handshake.
// PARAMETERS
// DW   16  input operand width (pkg_system_mdr::DW); internal operand width DW2 = 2*DW
// PORTS
// clk        in   1    system clock, all logic on rising edge
// rst        in   1    synchronous reset, active-high
// start      in   1    begin new transaction; sampled only in IDLE
// load       in   1    operand load strobe, level input; internally edge-detected
// op         in   2    op_t {MULT, DIV, ROOT}; latched when start is accepted
// data_in    in   DW   signed two's-complement operand bus (data_in_t)
// x_mag      out  DW2  |X| zero-extended (data_t)
// y_mag      out  DW2  |Y| zero-extended; 0 for ROOT
// res_neg    out  1    result sign: X[DW-1]^Y[DW-1] for MULT/DIV, forced 0 if X==0 or op==ROOT
// op_out     out  2    latched op_t
// op_valid   out  1    operands valid for core; asserted only in INIT
// op_accept  in   1    core takes operands when op_valid && op_accept
// error      out  1    sticky: invalid operands detected
// busy       out  1    high in every state except IDLE
// state      out  4    current state_t, for debug/display
// BEHAVIOUR
// - Reset: state=IDLE; x_mag=y_mag=0; res_neg=0; op_out=MULT; op_valid=0; error=0; busy=0; load edge reg=0.
// - Reset mid-transaction: next cycle all outputs at reset values; no op_valid emitted.
// - Load edge: load_rise = load & ~load_q; load_q registered every cycle in every state (including IDLE).
// - FSM (uses pkg state_t subset; VERIFICATION/INIT as named; CALCULATION, READY unused):
//   IDLE: start=1 -> CLEAN; op latched into op_out same edge. start ignored in all other states.
//   CLEAN: one cycle; clears x_mag, y_mag, res_neg, error -> WAIT_X.
//   WAIT_X: on load_rise capture data_in as X_raw -> ROOT: VERIFICATION; else WAIT_Y.
//   WAIT_Y: on load_rise capture data_in as Y_raw -> VERIFICATION.
//   VERIFICATION: one cycle; DIV & Y_raw==0 -> error; ROOT & X_raw[DW-1] -> error.
//     error -> IDLE with error=1 (held until next CLEAN); else compute magnitudes/res_neg -> INIT.
//   INIT: op_valid=1, x_mag/y_mag/res_neg/op_out stable; op_valid&op_accept -> IDLE, op_valid=0 next cycle.
// - Load held high across state entry produces no capture; needs a new 0->1 transition.
// - start and load rise same cycle in IDLE: start accepted, load edge discarded (no capture in CLEAN).
// - Magnitude: abs of signed DW value, zero-extended to DW2; -2^(DW-1) -> 2^(DW-1) exactly (no overflow).
// - Latency: start -> CLEAN 1 cycle; last load_rise -> op_valid 2 cycles (VERIFICATION, then INIT).
// - op_accept outside INIT ignored. op_valid never high while error=1.
// STRUCTURE
// - pkg_system_mdr: reuse data_in_t, data_t, op_t, state_t, DW, DW2; add localparam OPX_RST='0.
// - Sub-module mdr_edge_detect (registered rising-edge detector, clk/rst/in -> rise) for load.
// - Single always_ff FSM + operand regs; always_comb next-state/verification logic; abs via function.
// TESTING
// - MULT: start, op=MULT, X=16'hFFFD(-3), Y=16'h0005 -> op_valid; x_mag=3, y_mag=5, res_neg=1, error=0.
// - DIV by zero: op=DIV, X=100, Y=0 -> error=1 after VERIFICATION, state IDLE, op_valid never asserted.
// - ROOT: X=16'd144 -> WAIT_Y skipped; x_mag=144, y_mag=0, res_neg=0. X=16'h8000 -> error=1.
// - Edge rule: load held high 5 cycles in WAIT_X -> single capture; stays WAIT_Y until load toggles.
// - Handshake: op_accept low 4 cycles in INIT -> op_valid and outputs stable; accept -> IDLE next cycle.
// - rst=1 in WAIT_Y -> next cycle IDLE, busy=0, x_mag=0; start again runs clean MULT 0*(-1) -> res_neg=0.

Source files
------------

// File: rtl/mdr_operand_loader_pkg.sv
// Shared types and constants for the multiply/divide/root system.
// Also holds the magnitude helper used by the operand loader.
package pkg_system_mdr;

    localparam int DW  = 16;
    localparam int DW2 = 2 * DW;

    typedef logic signed [DW-1:0] data_in_t;
    typedef logic        [DW2-1:0] data_t;

    typedef enum logic [1:0] {
        MULT = 2'd0,
        DIV  = 2'd1,
        ROOT = 2'd2
    } op_t;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        CLEAN        = 4'd1,
        WAIT_X       = 4'd2,
        WAIT_Y       = 4'd3,
        VERIFICATION = 4'd4,
        CALCULATION  = 4'd5,
        READY        = 4'd6,
        INIT         = 4'd7
    } state_t;

    localparam data_t OPX_RST = '0;

    // The most negative input maps to 2^(DW-1), which still fits once zero-extended.
    function automatic data_t abs_ext(input data_in_t v);
        logic [DW-1:0] one_v;
        logic [DW-1:0] mag_v;
        one_v = {{(DW-1){1'b0}}, 1'b1};
        if (v[DW-1]) begin
            mag_v = (~v) + one_v;
        end else begin
            mag_v = v;
        end
        return {{DW{1'b0}}, mag_v};
    endfunction

endpackage

// File: rtl/mdr_operand_loader_if.sv
// Operand bus between the upstream driver/core (master) and the operand loader (slave).
interface mdr_operand_loader_if;
    import pkg_system_mdr::*;

    logic     start;
    logic     load;
    op_t      op;
    data_in_t data_in;
    data_t    x_mag;
    data_t    y_mag;
    logic     res_neg;
    op_t      op_out;
    logic     op_valid;
    logic     op_accept;
    logic     error;
    logic     busy;
    state_t   state;

    modport master (
        output start, load, op, data_in, op_accept,
        input  x_mag, y_mag, res_neg, op_out, op_valid, error, busy, state
    );

    modport slave (
        input  start, load, op, data_in, op_accept,
        output x_mag, y_mag, res_neg, op_out, op_valid, error, busy, state
    );

endinterface

// File: rtl/mdr_operand_loader_edge_detect.sv
// Rising-edge detector: the previous input level is registered every cycle.
module mdr_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q_r;

    // Previous-cycle level of the input
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q_r <= 1'b0;
        end else begin
            in_q_r <= in;
        end
    end

    assign rise = in & ~in_q_r;

endmodule

// File: rtl/mdr_operand_loader.sv
// Captures op and operands from the shared bus, validates them and presents
// magnitudes plus result sign to the calculation core with a valid/accept handshake.
module mdr_operand_loader
    import pkg_system_mdr::*;
(
    input logic                 clk,
    input logic                 rst,
    mdr_operand_loader_if.slave bus
);

    logic     load_rise_s;
    state_t   state_r, next_state_s;
    data_in_t x_raw_r, y_raw_r;
    data_t    x_mag_r, y_mag_r;
    data_t    x_mag_s, y_mag_s;
    logic     res_neg_r, res_neg_s;
    op_t      op_r;
    logic     op_valid_r, error_r, busy_r;
    logic     verify_err_s;

    mdr_edge_detect u_load_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (bus.load),
        .rise (load_rise_s)
    );

    // Operand checks and result magnitudes evaluated from the raw captures
    always_comb begin
        verify_err_s = 1'b0;
        x_mag_s      = abs_ext(x_raw_r);
        y_mag_s      = OPX_RST;
        res_neg_s    = 1'b0;
        if ((op_r == DIV) && (y_raw_r == {DW{1'b0}})) begin
            verify_err_s = 1'b1;
        end else if ((op_r == ROOT) && x_raw_r[DW-1]) begin
            verify_err_s = 1'b1;
        end else begin
            verify_err_s = 1'b0;
        end
        if (op_r != ROOT) begin
            y_mag_s   = abs_ext(y_raw_r);
            res_neg_s = (x_raw_r != {DW{1'b0}}) ? (x_raw_r[DW-1] ^ y_raw_r[DW-1]) : 1'b0;
        end else begin
            y_mag_s   = OPX_RST;
            res_neg_s = 1'b0;
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:         next_state_s = bus.start ? CLEAN : IDLE;
            CLEAN:        next_state_s = WAIT_X;
            WAIT_X: begin
                if (load_rise_s) begin
                    next_state_s = (op_r == ROOT) ? VERIFICATION : WAIT_Y;
                end else begin
                    next_state_s = WAIT_X;
                end
            end
            WAIT_Y:       next_state_s = load_rise_s ? VERIFICATION : WAIT_Y;
            VERIFICATION: next_state_s = verify_err_s ? IDLE : INIT;
            INIT:         next_state_s = bus.op_accept ? IDLE : INIT;
            default:      next_state_s = IDLE;
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            x_raw_r    <= {DW{1'b0}};
            y_raw_r    <= {DW{1'b0}};
            x_mag_r    <= OPX_RST;
            y_mag_r    <= OPX_RST;
            res_neg_r  <= 1'b0;
            op_r       <= MULT;
            op_valid_r <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            busy_r     <= (next_state_s != IDLE);
            op_valid_r <= (next_state_s == INIT);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_r <= bus.op;
                    end
                end
                CLEAN: begin
                    x_raw_r   <= {DW{1'b0}};
                    y_raw_r   <= {DW{1'b0}};
                    x_mag_r   <= OPX_RST;
                    y_mag_r   <= OPX_RST;
                    res_neg_r <= 1'b0;
                    error_r   <= 1'b0;
                end
                WAIT_X: begin
                    if (load_rise_s) begin
                        x_raw_r <= bus.data_in;
                    end
                end
                WAIT_Y: begin
                    if (load_rise_s) begin
                        y_raw_r <= bus.data_in;
                    end
                end
                VERIFICATION: begin
                    if (verify_err_s) begin
                        error_r <= 1'b1;
                    end else begin
                        x_mag_r   <= x_mag_s;
                        y_mag_r   <= y_mag_s;
                        res_neg_r <= res_neg_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.x_mag    = x_mag_r;
    assign bus.y_mag    = y_mag_r;
    assign bus.res_neg  = res_neg_r;
    assign bus.op_out   = op_r;
    assign bus.op_valid = op_valid_r;
    assign bus.error    = error_r;
    assign bus.busy     = busy_r;
    assign bus.state    = state_r;

endmodule
